// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the PS/2 pins, then
// assembles 11-bit frames into bytes with a valid strobe and coded error pulses.
module ps2_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state, state_n;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          clk_f, clk_f_prev, fall;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic          tmo_hit;
    logic          ev_valid, ev_err;
    logic [1:0]    ev_code;

    assign clk_s   = clk_sync[1];
    assign dat_s   = dat_sync[1];
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
    assign busy    = (state == RECV);

    // Synchronizers idle high so a reset never looks like a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_f      <= 1'b1;
            clk_f_prev <= 1'b1;
            fall       <= 1'b0;
            filt_cnt   <= '0;
        end else begin
            clk_f_prev <= clk_f;
            fall       <= clk_f_prev & ~clk_f;
            if (clk_s == clk_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER - 1)) begin
                clk_f    <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A fall always wins over the timeout threshold
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (fall && !dat_s) state_n = RECV;
            RECV: begin
                if (fall) begin
                    if (bit_cnt == 4'd10) state_n = IDLE;
                end else if (tmo_hit) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_err   = 1'b0;
        ev_code  = 2'd0;
        case (state)
            IDLE: begin
                if (fall && dat_s) begin
                    ev_err  = 1'b1;
                    ev_code = 2'd0;
                end
            end
            RECV: begin
                if (fall) begin
                    if (bit_cnt == 4'd10) begin
                        if (^{shift, parity} != 1'b1) begin
                            ev_err  = 1'b1;
                            ev_code = 2'd1;
                        end else if (!dat_s) begin
                            ev_err  = 1'b1;
                            ev_code = 2'd2;
                        end else begin
                            ev_valid = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    ev_err  = 1'b1;
                    ev_code = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            valid <= ev_valid;
            err   <= ev_err;
            if (ev_err) err_code <= ev_code;
            if (ev_valid) data <= shift;

            if (state_n == IDLE) begin
                bit_cnt <= '0;
            end else if (fall) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (state_n == RECV && !fall) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end

            // Data arrives LSB first, so shift in from the top
            if (state == RECV && fall) begin
                if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) begin
                    shift <= {dat_s, shift[7:1]};
                end else if (bit_cnt == 4'd9) begin
                    parity <= dat_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Testbench for ps2_rx: drives PS/2 frames bit by bit and compares every valid/err
// pulse against a frame-level reference model of the protocol.
module tb_ps2_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 50000;
    localparam int HALF    = 20;
    // Result shows on the (2 sync + FILTER + 2)th clock edge after a raw fall
    localparam int LAT     = FILTER + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int         check_cnt = 0;
    int         pass_cnt  = 0;
    logic [8:0] ev_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] model_data;

    ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .data     (data),
        .valid    (valid),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    // Every strobe is logged as {is_err, byte or error code}
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid) ev_q.push_back({1'b0, data});
            if (err) ev_q.push_back({1'b1, 6'd0, err_code});
        end
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Protocol-level outcome of one complete frame
    function automatic logic [8:0] frame_outcome(input logic [7:0] d, input logic par, input logic stop);
        if ((($countones(d) + int'(par)) % 2) != 1) return {1'b1, 8'd1};
        if (stop !== 1'b1) return {1'b1, 8'd2};
        return {1'b0, d};
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic expect_event(input logic [8:0] ev);
        exp_q.push_back(ev);
        if (!ev[8]) model_data = ev[7:0];
    endtask

    task automatic apply_stimulus(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic par, input logic stop);
        apply_stimulus({stop, par, d, 1'b0}, 11);
        ps2_dat = 1'b1;
        expect_event(frame_outcome(d, par, stop));
    endtask

    task automatic check_events(input string tag);
        int n;
        wait_cyc(5);
        check_output({tag, "_count"}, 16'(ev_q.size()), 16'(exp_q.size()));
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output({tag, "_event"}, 16'(ev_q[i]), 16'(exp_q[i]));
        end
        ev_q.delete();
        exp_q.delete();
        check_output({tag, "_data"}, 16'(data), 16'(model_data));
    endtask

    initial begin
        logic [10:0] frame;
        logic [7:0]  d;
        int          kind;

        rst        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_dat    = 1'b1;
        model_data = 8'h00;
        wait_cyc(3);
        check_output("reset_data", 16'(data), 16'h0);
        check_output("reset_valid", 16'(valid), 16'h0);
        check_output("reset_err", 16'(err), 16'h0);
        check_output("reset_err_code", 16'(err_code), 16'h0);
        check_output("reset_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        wait_cyc(5);

        $display("[TB] single frame 0x1C");
        frame = {1'b1, 1'b0, 8'h1C, 1'b0};
        apply_stimulus(frame, 3);
        check_output("busy_mid_frame", 16'(busy), 16'h1);
        apply_stimulus(frame >> 3, 8);
        ps2_dat = 1'b1;
        expect_event(frame_outcome(8'h1C, 1'b0, 1'b1));
        check_output("busy_after_frame", 16'(busy), 16'h0);
        check_events("frame_1c");

        $display("[TB] back to back 0xF0, 0x1C");
        send_byte(8'hF0, odd_par(8'hF0), 1'b1);
        send_byte(8'h1C, odd_par(8'h1C), 1'b1);
        check_events("back_to_back");

        $display("[TB] bad parity");
        send_byte(8'h1C, 1'b1, 1'b1);
        check_output("parity_err_code", 16'(err_code), 16'h1);
        check_events("bad_parity");

        $display("[TB] glitch then 0x5A");
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(30);
        check_output("glitch_busy", 16'(busy), 16'h0);
        check_events("glitch");
        send_byte(8'h5A, odd_par(8'h5A), 1'b1);
        check_events("frame_5a");

        $display("[TB] bad stop bit");
        d = 8'($urandom);
        send_byte(d, odd_par(d), 1'b0);
        check_output("stop_err_code", 16'(err_code), 16'h2);
        check_events("bad_stop");

        $display("[TB] bad start bit");
        apply_stimulus(11'h001, 1);
        expect_event({1'b1, 8'd0});
        check_output("start_err_busy", 16'(busy), 16'h0);
        check_events("bad_start");
        check_output("start_err_code", 16'(err_code), 16'h0);

        $display("[TB] random frames");
        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 2));
            send_byte(d, (kind == 1) ? ~odd_par(d) : odd_par(d), (kind == 2) ? 1'b0 : 1'b1);
            check_events("random");
        end

        $display("[TB] timeout");
        frame = {1'b1, odd_par(8'hA5), 8'hA5, 1'b0};
        apply_stimulus(frame, 4);
        ps2_dat = frame[4];
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(LAT + TIMEOUT - HALF);
        check_output("timeout_err_early", 16'(err), 16'h0);
        check_output("timeout_busy_before", 16'(busy), 16'h1);
        wait_cyc(1);
        check_output("timeout_err", 16'(err), 16'h1);
        check_output("timeout_err_code", 16'(err_code), 16'h3);
        check_output("timeout_busy_after", 16'(busy), 16'h0);
        expect_event({1'b1, 8'd3});
        check_events("timeout");
        d = 8'($urandom);
        send_byte(d, odd_par(d), 1'b1);
        check_events("after_timeout");

        $display("[TB] reset mid-frame");
        apply_stimulus({1'b1, odd_par(8'h33), 8'h33, 1'b0}, 6);
        rst = 1'b1;
        wait_cyc(1);
        check_output("midrst_data", 16'(data), 16'h0);
        check_output("midrst_valid", 16'(valid), 16'h0);
        check_output("midrst_err", 16'(err), 16'h0);
        check_output("midrst_err_code", 16'(err_code), 16'h0);
        check_output("midrst_busy", 16'(busy), 16'h0);
        rst        = 1'b0;
        ps2_dat    = 1'b1;
        model_data = 8'h00;
        wait_cyc(5);
        send_byte(8'h5A, odd_par(8'h5A), 1'b1);
        check_events("after_reset");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
